// File: rtl/dram_arbiter.sv
// Single-port DRAM arbiter: serialises a write stream and a readback stream onto a
// MIG-style command / write-data / read-return interface, one transaction at a time.
module dram_arbiter #(
   parameter int ADX_WIDTH     = 27,
   parameter int MEM_IF_WIDTH  = 128,
   parameter int MAX_WR_STREAK = 8,
   parameter int RD_TIMEOUT    = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_req,
   input  logic [ADX_WIDTH-1:0]    wr_adx,
   input  logic [MEM_IF_WIDTH-1:0] wr_data,
   output logic                    wr_grant,
   input  logic                    rd_req,
   input  logic [ADX_WIDTH-1:0]    rd_adx,
   output logic                    rd_grant,
   output logic [MEM_IF_WIDTH-1:0] rd_data,
   output logic                    rd_valid,
   output logic                    rd_error,
   output logic                    busy,
   input  logic                    calib_done,
   output logic                    mem_cmd_en,
   output logic [2:0]              mem_cmd_instr,
   output logic [ADX_WIDTH-1:0]    mem_cmd_addr,
   input  logic                    mem_cmd_rdy,
   output logic [MEM_IF_WIDTH-1:0] mem_wdf_data,
   output logic                    mem_wdf_wren,
   output logic                    mem_wdf_end,
   input  logic                    mem_wdf_rdy,
   input  logic [MEM_IF_WIDTH-1:0] mem_rd_data,
   input  logic                    mem_rd_data_valid,
   output logic [2:0]              dbg_state
);

   // Handshakes: a memory port transfers on the rising edge where its enable and its
   // rdy are both high; enables depend only on state, never on rdy. Requesters hold
   // *_req until the one-cycle *_grant pulse that follows the accepting edge.
   typedef enum logic [2:0] {
      ST_INIT, ST_IDLE, ST_WR_DATA, ST_WR_CMD, ST_RD_CMD, ST_RD_WAIT
   } state_t;

   localparam int STREAK_W = $clog2(MAX_WR_STREAK + 1);
   localparam logic [STREAK_W-1:0]  STREAK_MAX = STREAK_W'(MAX_WR_STREAK);
   localparam logic [15:0]          TMO_LAST   = 16'(RD_TIMEOUT - 1);
   localparam logic [ADX_WIDTH-1:0] ADX_ALIGN  = ~(ADX_WIDTH'(7));
   localparam logic [2:0]           INSTR_WR   = 3'b000;
   localparam logic [2:0]           INSTR_RD   = 3'b001;

   state_t                  state, state_nxt;
   logic [STREAK_W-1:0]     streak;
   logic [15:0]             tmo_cnt;
   logic [ADX_WIDTH-1:0]    adx_q;
   logic [MEM_IF_WIDTH-1:0] wdata_q;
   logic [ADX_WIDTH-1:0]    adx_sel;
   logic                    grant_wr, grant_rd, rd_done, rd_abort;
   logic                    streak_full;

   assign streak_full = (streak == STREAK_MAX);
   assign adx_sel     = grant_rd ? rd_adx : wr_adx;
   assign dbg_state   = state;
   assign busy        = !reset && (state != ST_IDLE);

   always_comb begin
      state_nxt     = state;
      grant_wr      = 1'b0;
      grant_rd      = 1'b0;
      rd_done       = 1'b0;
      rd_abort      = 1'b0;
      mem_cmd_en    = 1'b0;
      mem_cmd_instr = INSTR_WR;
      mem_cmd_addr  = '0;
      mem_wdf_data  = '0;
      mem_wdf_wren  = 1'b0;
      mem_wdf_end   = 1'b0;

      case (state)
         ST_WR_DATA: begin
            mem_wdf_wren = 1'b1;
            mem_wdf_end  = 1'b1;
            mem_wdf_data = wdata_q;
         end
         ST_WR_CMD: begin
            mem_cmd_en   = 1'b1;
            mem_cmd_addr = adx_q;
         end
         ST_RD_CMD: begin
            mem_cmd_en    = 1'b1;
            mem_cmd_instr = INSTR_RD;
            mem_cmd_addr  = adx_q;
         end
         default: ;
      endcase

      // Losing calibration overrides everything, including a pending grant or pulse.
      if (!calib_done) begin
         state_nxt = ST_INIT;
      end else begin
         case (state)
            ST_INIT: state_nxt = ST_IDLE;
            ST_IDLE: begin
               if (rd_req && (!wr_req || streak_full)) begin
                  grant_rd  = 1'b1;
                  state_nxt = ST_RD_CMD;
               end else if (wr_req) begin
                  grant_wr  = 1'b1;
                  state_nxt = ST_WR_DATA;
               end
            end
            ST_WR_DATA: if (mem_wdf_rdy) state_nxt = ST_WR_CMD;
            ST_WR_CMD:  if (mem_cmd_rdy) state_nxt = ST_IDLE;
            ST_RD_CMD:  if (mem_cmd_rdy) state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: begin
               if (mem_rd_data_valid) begin
                  rd_done   = 1'b1;
                  state_nxt = ST_IDLE;
               end else if (tmo_cnt == TMO_LAST) begin
                  rd_abort  = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
            default: state_nxt = ST_INIT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_INIT;
         wr_grant <= 1'b0;
         rd_grant <= 1'b0;
         rd_valid <= 1'b0;
         rd_error <= 1'b0;
         rd_data  <= '0;
         adx_q    <= '0;
         wdata_q  <= '0;
         streak   <= '0;
         tmo_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         wr_grant <= grant_wr;
         rd_grant <= grant_rd;
         rd_valid <= rd_done;
         rd_error <= rd_abort;
         if (grant_wr || grant_rd) adx_q <= adx_sel & ADX_ALIGN;
         if (grant_wr) wdata_q <= wr_data;
         if (rd_done) rd_data <= mem_rd_data;
         if (state == ST_RD_CMD) tmo_cnt <= '0;
         else if (state == ST_RD_WAIT) tmo_cnt <= tmo_cnt + 16'd1;
         // Streak only counts writes that overtook a waiting read.
         if (!rd_req || grant_rd) streak <= '0;
         else if (grant_wr && !streak_full) streak <= streak + 1'b1;
      end
   end

endmodule
